regread_ctrl: RTL

REGREAD_CTRL -- requirements
Module: regread_ctrl

---
 rtl/regread_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/regread_ctrl.sv
// Register-read controller: sequences up to two operand reads through one shared RF read port.
// Optional macro REGREAD_BYPASS_EN forwards a same-cycle writeback instead of reading the RF.
module regread_ctrl #(
  parameter int NUM_UOPS      = 32,
  parameter int XLEN          = 32,
  parameter int ARCHFILE_SIZE = 32,
  localparam int UW = $clog2(NUM_UOPS),
  localparam int AW = $clog2(ARCHFILE_SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [UW-1:0]   uop_in,
  input  logic            eoi_in,
  input  logic [AW-1:0]   dest_arch_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic            use_imm_in,
  input  logic [31:0]     pc_in,
  input  logic            except_in,
  input  logic [AW-1:0]   rs1_arch_in,
  input  logic [AW-1:0]   rs2_arch_in,
  input  logic            use_rs1_in,
  input  logic            use_rs2_in,
  output logic            rf_ren,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_arch,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [UW-1:0]   uop_out,
  output logic            eoi_out,
  output logic [AW-1:0]   dest_arch_out,
  output logic [XLEN-1:0] imm_out,
  output logic            use_imm_out,
  output logic [31:0]     pc_out,
  output logic            except_out,
  output logic [XLEN-1:0] src1_out,
  output logic [XLEN-1:0] src2_out
);

  // state | meaning
  // IDLE  | waiting for a packet
  // RS1   | reading source 1
  // RS2   | reading source 2 (captures source 1 data)
  // FIN   | capturing the last read data
  // OUT   | presenting packet downstream
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RS1  = 3'd1;
  localparam logic [2:0] S_RS2  = 3'd2;
  localparam logic [2:0] S_FIN  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]    state, state_nxt, route;
  logic [AW-1:0] rs1_q, rs2_q;
  logic          rd2_q;
  logic          pend, pend_sel;
  logic          accept, rd1_in, rd2_in, in_rs, byp;

  assign in_ready  = !flush && ((state == S_IDLE) || ((state == S_OUT) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_OUT);
  assign rd1_in    = use_rs1_in && (rs1_arch_in != '0) && !except_in;
  assign rd2_in    = use_rs2_in && (rs2_arch_in != '0) && !except_in;
  assign route     = rd1_in ? S_RS1 : (rd2_in ? S_RS2 : S_OUT);
  assign in_rs     = (state == S_RS1) || (state == S_RS2);
  assign rf_raddr  = (state == S_RS1) ? rs1_q : ((state == S_RS2) ? rs2_q : '0);

`ifdef REGREAD_BYPASS_EN
  assign byp = in_rs && wb_valid && (wb_arch == rf_raddr) && (rf_raddr != '0);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_arch, wb_data};
  assign byp       = 1'b0;
`endif

  assign rf_ren = in_rs && !byp;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = route;
      S_RS1:   state_nxt = rd2_q ? S_RS2 : S_FIN;
      S_RS2:   state_nxt = S_FIN;
      S_FIN:   state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = accept ? route : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd2_q         <= 1'b0;
      pend          <= 1'b0;
      pend_sel      <= 1'b0;
      uop_out       <= '0;
      eoi_out       <= 1'b0;
      dest_arch_out <= '0;
      imm_out       <= '0;
      use_imm_out   <= 1'b0;
      pc_out        <= '0;
      except_out    <= 1'b0;
      src1_out      <= '0;
      src2_out      <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        pend <= 1'b0;
      end else begin
        // RF data arrives one cycle after the read; pend_sel remembers which source it belongs to
        pend     <= rf_ren;
        pend_sel <= (state == S_RS2);
        if (pend) begin
          if (pend_sel) src2_out <= rf_rdata;
          else          src1_out <= rf_rdata;
        end
        if (byp) begin
          if (state == S_RS2) src2_out <= wb_data;
          else                src1_out <= wb_data;
        end
        if (accept) begin
          uop_out       <= uop_in;
          eoi_out       <= eoi_in;
          dest_arch_out <= dest_arch_in;
          imm_out       <= imm_in;
          use_imm_out   <= use_imm_in;
          pc_out        <= pc_in;
          except_out    <= except_in;
          src1_out      <= '0;
          src2_out      <= '0;
          rs1_q         <= rs1_arch_in;
          rs2_q         <= rs2_arch_in;
          rd2_q         <= rd2_in;
        end
      end
    end
  end

endmodule
